calc_exec_core: RTL

//  Parametrised successor to the 4-register, 8-bit PUSH/ADD/MULT/SEND calculator core.
//  - Register count and data width are parameters.
//  - Instruction intake uses a valid/ready handshake.
//  - MULT is a multi-cycle shift-add sequence.
//  - SEND drives a valid/ready byte/word stream toward the UART transmitter.
//  - Sits between the debounced switch/button instruction source and the UART TX block.

---
 rtl/calc_exec_core_if.sv | 28 ++
 rtl/calc_exec_core.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_exec_core_if.sv
// Instruction intake, SEND byte/word stream and status lines of calc_exec_core.
// The core is the slave; the instruction source and the UART TX side form the master.
interface calc_exec_core_if #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4
);
    localparam int REG_AW = $clog2(NREG);
    localparam int INST_W = 2 + 3*REG_AW;

    logic [INST_W-1:0] inst_wd;
    logic              inst_vld;
    logic              inst_rdy;
    logic [DATA_W-1:0] tx_data;
    logic              tx_vld;
    logic              tx_rdy;
    logic [DATA_W-1:0] wr_data;
    logic              busy;

    modport master (
        output inst_wd, inst_vld, tx_rdy,
        input  inst_rdy, tx_data, tx_vld, wr_data, busy
    );

    modport slave (
        input  inst_wd, inst_vld, tx_rdy,
        output inst_rdy, tx_data, tx_vld, wr_data, busy
    );
endinterface

// File: rtl/calc_exec_core.sv
// PUSH/ADD/MULT/SEND calculator core with NREG registers of DATA_W bits and a shift-add multiplier.
// Optional feature macro CALC_SAT_EN: signed saturation of ADD and MULT results instead of wrap-around.
module calc_exec_core #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    calc_exec_core_if.slave bus
);
    localparam int REG_AW = $clog2(NREG);
    localparam int INST_W = 2 + 3*REG_AW;
    localparam int CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W-1);
    localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_ADD  = 2'b01,
        OP_MULT = 2'b10,
        OP_SEND = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_SEND
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic                r_live;
    logic [DATA_W-1:0]   r_regs [NREG];
    logic [DATA_W-1:0]   r_wrData;
    logic [DATA_W-1:0]   r_txData;
    logic                r_txVld;
    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [CNT_W-1:0]    r_cnt;
    logic [REG_AW-1:0]   r_dst;

    op_t                     w_op;
    logic [REG_AW-1:0]       w_ra;
    logic [REG_AW-1:0]       w_rb;
    logic [REG_AW-1:0]       w_rc;
    logic signed [2*REG_AW-1:0] w_immRaw;
    logic [DATA_W-1:0]       w_imm;
    logic [DATA_W-1:0]       w_opB;
    logic [DATA_W-1:0]       w_opC;
    logic [DATA_W-1:0]       w_sum;
    logic [DATA_W-1:0]       w_addRes;
    logic [2*DATA_W-1:0]     w_term;
    logic [2*DATA_W-1:0]     w_accNext;
    logic [DATA_W-1:0]       w_mulRes;
    logic                    w_inRdy;
    logic                    w_accept;
    logic                    w_mulStart;
    logic                    w_regWe;
    logic [REG_AW-1:0]       w_regWaddr;
    logic [DATA_W-1:0]       w_regWdata;
    logic                    w_txLoad;
    logic                    w_txDone;

    assign w_op     = op_t'(bus.inst_wd[INST_W-1 -: 2]);
    assign w_ra     = bus.inst_wd[3*REG_AW-1 -: REG_AW];
    assign w_rb     = bus.inst_wd[2*REG_AW-1 -: REG_AW];
    assign w_rc     = bus.inst_wd[REG_AW-1:0];
    assign w_immRaw = {w_rb, w_rc};
    assign w_imm    = DATA_W'(w_immRaw);
    assign w_opB    = r_regs[w_rb];
    assign w_opC    = r_regs[w_rc];
    assign w_sum    = w_opB + w_opC;

    // Signed shift-add: the multiplier MSB carries negative weight, so the last step subtracts.
    assign w_term    = r_mplier[0] ? r_mcand : '0;
    assign w_accNext = (r_cnt == CNT_LAST) ? (r_acc - w_term) : (r_acc + w_term);

`ifdef CALC_SAT_EN
    always_comb begin
        w_addRes = w_sum;
        if ((w_opB[DATA_W-1] == w_opC[DATA_W-1]) && (w_sum[DATA_W-1] != w_opB[DATA_W-1])) begin
            w_addRes = w_opB[DATA_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // The product fits when its top DATA_W+1 bits are all copies of the sign.
    always_comb begin
        w_mulRes = w_accNext[DATA_W-1:0];
        if (!((&w_accNext[2*DATA_W-1:DATA_W-1]) || !(|w_accNext[2*DATA_W-1:DATA_W-1]))) begin
            w_mulRes = w_accNext[2*DATA_W-1] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign w_addRes = w_sum;
    assign w_mulRes = w_accNext[DATA_W-1:0];
`endif

    // r_live keeps inst_rdy low until the first clock edge after reset release.
    assign w_inRdy      = r_live && (r_state == S_IDLE);
    assign bus.inst_rdy = w_inRdy;
    assign bus.busy     = (r_state == S_MUL) || (r_state == S_SEND);
    assign bus.tx_data  = r_txData;
    assign bus.tx_vld   = r_txVld;
    assign bus.wr_data  = r_wrData;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_mulStart  = 1'b0;
        w_regWe     = 1'b0;
        w_regWaddr  = w_ra;
        w_regWdata  = w_imm;
        w_txLoad    = 1'b0;
        w_txDone    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.inst_vld && w_inRdy) begin
                    w_accept = 1'b1;
                    case (w_op)
                        OP_PUSH: begin
                            w_regWe    = 1'b1;
                            w_regWdata = w_imm;
                        end
                        OP_ADD: begin
                            w_regWe    = 1'b1;
                            w_regWdata = w_addRes;
                        end
                        OP_MULT: begin
                            w_mulStart  = 1'b1;
                            w_stateNext = S_MUL;
                        end
                        OP_SEND: begin
                            w_txLoad    = 1'b1;
                            w_stateNext = S_SEND;
                        end
                    endcase
                end
            end
            S_MUL: begin
                if (r_cnt == CNT_LAST) begin
                    w_regWe     = 1'b1;
                    w_regWaddr  = r_dst;
                    w_regWdata  = w_mulRes;
                    w_stateNext = S_IDLE;
                end
            end
            S_SEND: begin
                if (r_txVld && bus.tx_rdy) begin
                    w_txDone    = 1'b1;
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_wrData <= '0;
        end else if (w_regWe) begin
            r_regs[w_regWaddr] <= w_regWdata;
            r_wrData           <= w_regWdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txData <= '0;
            r_txVld  <= 1'b0;
        end else if (w_txLoad) begin
            r_txData <= r_regs[w_ra];
            r_txVld  <= 1'b1;
        end else if (w_txDone) begin
            r_txVld  <= 1'b0;
        end
    end

    // Operands are captured at accept, so the destination may alias either source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_dst    <= '0;
        end else if (w_accept && w_mulStart) begin
            r_acc    <= '0;
            r_mcand  <= {{DATA_W{w_opB[DATA_W-1]}}, w_opB};
            r_mplier <= w_opC;
            r_cnt    <= '0;
            r_dst    <= w_ra;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end
endmodule
